// File: rtl/seg_pkg.sv
// Shared definitions for the shared 4-digit seven-segment display controller.
// Holds the digit glyphs, the blank glyph, the controller state encoding and
// the requester index constants.
//   Glyph bit order is {a,b,c,d,e,f,g,dp}, active-high, a = MSB. The decimal
//   point bit is always 0 in these constants and is merged in by the decoder.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'b1111_1100;
  localparam logic [7:0] SEG_1     = 8'b0110_0000;
  localparam logic [7:0] SEG_2     = 8'b1101_1010;
  localparam logic [7:0] SEG_3     = 8'b1111_0010;
  localparam logic [7:0] SEG_4     = 8'b0110_0110;
  localparam logic [7:0] SEG_5     = 8'b1011_0110;
  localparam logic [7:0] SEG_6     = 8'b1011_1110;
  localparam logic [7:0] SEG_7     = 8'b1110_0000;
  localparam logic [7:0] SEG_8     = 8'b1111_1110;
  localparam logic [7:0] SEG_9     = 8'b1111_0110;
  localparam logic [7:0] SEG_BLANK = 8'b0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    OWN   = 2'd2
  } state_t;

  // Requester indices into req / grant.
  localparam int REQ_TRIP  = 0;
  localparam int REQ_STATE = 1;
  localparam int REQ_ALERT = 2;

  typedef logic [1:0] owner_t;

endpackage

// File: rtl/seg_share_ctrl_if.sv
// Bus bundle between the display requesters and seg_share_ctrl.
//   req        : display requests [0] trip timer, [1] car state, [2] alert
//   bcd0..bcd2 : four BCD digits per requester, [3:0] = rightmost digit
//   dp0..dp2   : decimal-point mask per requester, bit n = digit n
//   seg_out    : segments {a,b,c,d,e,f,g,dp}, active-high
//   seg_en     : one-hot digit enable, 4'b0001 = digit 0
//   grant      : one-hot current owner, 3'b000 when none
//   switching  : high during the blanking cycle between owners
// master = requester side, slave = controller side.
interface seg_share_ctrl_if;
  logic [2:0]  req;
  logic [15:0] bcd0;
  logic [15:0] bcd1;
  logic [15:0] bcd2;
  logic [3:0]  dp0;
  logic [3:0]  dp1;
  logic [3:0]  dp2;
  logic [7:0]  seg_out;
  logic [3:0]  seg_en;
  logic [2:0]  grant;
  logic        switching;

  modport master (
    output req, bcd0, bcd1, bcd2, dp0, dp1, dp2,
    input  seg_out, seg_en, grant, switching
  );

  modport slave (
    input  req, bcd0, bcd1, bcd2, dp0, dp1, dp2,
    output seg_out, seg_en, grant, switching
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder.
//   bcd : 4-bit digit; 0-9 decode to glyphs, 10-15 decode to all segments off
//   dp  : decimal point, always copied to seg[0] (also for blanked codes)
//   seg : {a,b,c,d,e,f,g,dp}, active-high
module bcd_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] glyph;

  always_comb begin
    glyph = SEG_BLANK;
    case (bcd)
      4'd0:    glyph = SEG_0;
      4'd1:    glyph = SEG_1;
      4'd2:    glyph = SEG_2;
      4'd3:    glyph = SEG_3;
      4'd4:    glyph = SEG_4;
      4'd5:    glyph = SEG_5;
      4'd6:    glyph = SEG_6;
      4'd7:    glyph = SEG_7;
      4'd8:    glyph = SEG_8;
      4'd9:    glyph = SEG_9;
      default: glyph = SEG_BLANK;
    endcase
    // Glyph constants carry dp = 0, so OR-ing places the decimal point.
    seg = glyph | {7'b000_0000, dp};
  end

endmodule

// File: rtl/seg_share_ctrl.sv
// Arbiter and multiplexer that lets three requesters share one 4-digit
// seven-segment display.
//   clk   : system clock, posedge
//   rst_n : asynchronous active-low reset
//   bus   : seg_share_ctrl_if.slave (requests, digit data in; segments,
//           digit enables, grant and switching out)
// The alert requester (2) preempts immediately and keeps the display while it
// requests. Requesters 0 and 1 share round-robin; an owner keeps the display
// for at least MIN_HOLD cycles before rotating to a waiting peer. Every owner
// change passes through one blank cycle.
module seg_share_ctrl
  import seg_pkg::*;
#(
  parameter int SCAN_TICKS = 330000,
  parameter int MIN_HOLD   = 100000000
) (
  input logic             clk,
  input logic             rst_n,
  seg_share_ctrl_if.slave bus
);

  localparam int HOLD_W = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
  localparam int SCAN_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MIN_HOLD);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_TICKS - 1);
  localparam owner_t OWNER_ALERT = owner_t'(REQ_ALERT);

  state_t              state_reg, state_next;
  owner_t              owner_reg, owner_next;
  logic                rr_reg, rr_next;       // 0/1 requester tried first
  logic [HOLD_W-1:0]   hold_reg, hold_next;
  logic [SCAN_W-1:0]   scan_reg, scan_next;
  logic [1:0]          digit_reg, digit_next;
  logic [7:0]          seg_out_reg;
  logic [3:0]          seg_en_reg, seg_en_next;

  logic [HOLD_W-1:0]   hold_inc;
  logic                hold_done;
  logic                owner_req;
  logic                other_req;
  owner_t              sel_owner;

  // Alert first, otherwise the round-robin favourite if it is requesting,
  // otherwise its peer. Only consulted when some request is high.
  function automatic owner_t pick_owner(input logic [2:0] r, input logic rr);
    logic rr_hit;
    rr_hit = rr ? r[1] : r[0];
    if (r[REQ_ALERT]) return OWNER_ALERT;
    return rr_hit ? {1'b0, rr} : {1'b0, ~rr};
  endfunction

  assign sel_owner = pick_owner(bus.req, rr_reg);
  assign owner_req = (owner_reg == OWNER_ALERT) ? bus.req[2] :
                     (owner_reg[0] ? bus.req[1] : bus.req[0]);
  assign other_req = owner_reg[0] ? bus.req[0] : bus.req[1];

  // The current OWN cycle counts toward the hold, so rotation happens after
  // exactly MIN_HOLD OWN cycles.
  assign hold_inc  = (hold_reg == HOLD_MAX) ? hold_reg : hold_reg + HOLD_W'(1);
  assign hold_done = (hold_inc == HOLD_MAX);

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    rr_next    = rr_reg;
    hold_next  = hold_reg;
    scan_next  = scan_reg;
    digit_next = digit_reg;
    case (state_reg)
      IDLE: begin
        hold_next  = '0;
        scan_next  = '0;
        digit_next = '0;
        if (|bus.req) begin
          state_next = BLANK;
          owner_next = sel_owner;
        end
      end
      BLANK: begin
        // Each new owner starts its scan at the rightmost digit.
        state_next = OWN;
        hold_next  = '0;
        scan_next  = '0;
        digit_next = '0;
      end
      OWN: begin
        hold_next = hold_inc;
        if (scan_reg == SCAN_LAST) begin
          scan_next  = '0;
          digit_next = digit_reg + 2'd1;
        end else begin
          scan_next = scan_reg + SCAN_W'(1);
        end
        if (!owner_req) begin
          if (|bus.req) begin
            state_next = BLANK;
            owner_next = sel_owner;
          end else begin
            state_next = IDLE;
          end
        end else if (owner_reg != OWNER_ALERT) begin
          if (bus.req[REQ_ALERT]) begin
            state_next = BLANK;
            owner_next = OWNER_ALERT;
          end else if (hold_done && other_req) begin
            state_next = BLANK;
            owner_next = {1'b0, ~owner_reg[0]};
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // The requester not chosen becomes the favourite for the next pick.
    if (state_next == BLANK && state_reg != BLANK && owner_next != OWNER_ALERT)
      rr_next = ~owner_next[0];
  end

  // Display path: decode from the values the registers are about to take so
  // that the registered seg_en/seg_out line up with state and digit index.
  logic [15:0] word_sel;
  logic [3:0]  mask_sel;
  logic [3:0]  digit_bcd [4];
  logic [3:0]  bcd_sel;
  logic        dp_sel;
  logic [7:0]  seg_dec;

  always_comb begin
    case (owner_next)
      2'd2:    begin word_sel = bus.bcd2; mask_sel = bus.dp2; end
      2'd1:    begin word_sel = bus.bcd1; mask_sel = bus.dp1; end
      default: begin word_sel = bus.bcd0; mask_sel = bus.dp0; end
    endcase
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_digit
    assign digit_bcd[gi]   = word_sel[gi*4 +: 4];
    assign seg_en_next[gi] = (state_next == OWN) && (digit_next == 2'(gi));
  end

  assign bcd_sel = digit_bcd[digit_next];
  assign dp_sel  = mask_sel[digit_next];

  bcd_to_seg7 u_dec (
    .bcd (bcd_sel),
    .dp  (dp_sel),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      owner_reg   <= owner_t'(REQ_TRIP);
      rr_reg      <= 1'b0;
      hold_reg    <= '0;
      scan_reg    <= '0;
      digit_reg   <= '0;
      seg_out_reg <= SEG_BLANK;
      seg_en_reg  <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      rr_reg      <= rr_next;
      hold_reg    <= hold_next;
      scan_reg    <= scan_next;
      digit_reg   <= digit_next;
      seg_out_reg <= (state_next == OWN) ? seg_dec : SEG_BLANK;
      seg_en_reg  <= seg_en_next;
    end
  end

  logic [2:0] grant_w;

  always_comb begin
    grant_w = 3'b000;
    if (state_reg == OWN) begin
      case (owner_reg)
        2'd2:    grant_w = 3'b100;
        2'd1:    grant_w = 3'b010;
        default: grant_w = 3'b001;
      endcase
    end
  end

  assign bus.grant     = grant_w;
  assign bus.switching = (state_reg == BLANK);
  assign bus.seg_out   = seg_out_reg;
  assign bus.seg_en    = seg_en_reg;

endmodule

// File: tb/tb_seg_share_ctrl.sv
// Testbench for seg_share_ctrl with SCAN_TICKS=4, MIN_HOLD=20.
// A behavioural model tracks who owns the display and for how many cycles;
// the digit shown is derived from that age, and glyphs from a lookup table.
module tb_seg_share_ctrl;

  localparam int ST = 4;
  localparam int MH = 20;

  localparam int M_IDLE  = 0;
  localparam int M_BLANK = 1;
  localparam int M_SHOW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg_share_ctrl_if bus ();

  seg_share_ctrl #(.SCAN_TICKS(ST), .MIN_HOLD(MH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // model state
  int m_mode  = M_IDLE;
  int m_owner = 0;
  int m_first = 0;   // which of requesters 0/1 is preferred next
  int m_age   = 0;   // completed display cycles of the current owner

  function automatic logic [7:0] ref_glyph(input logic [3:0] d, input logic p);
    logic [6:0] g;
    case (d)
      4'd0: g = 7'b1111110;
      4'd1: g = 7'b0110000;
      4'd2: g = 7'b1101101;
      4'd3: g = 7'b1111001;
      4'd4: g = 7'b0110011;
      4'd5: g = 7'b1011011;
      4'd6: g = 7'b1011111;
      4'd7: g = 7'b1110000;
      4'd8: g = 7'b1111111;
      4'd9: g = 7'b1111011;
      default: g = 7'b0000000;
    endcase
    return {g, p};
  endfunction

  function automatic bit has_req(input logic [2:0] r, input int k);
    return (k == 0) ? r[0] : (k == 1) ? r[1] : r[2];
  endfunction

  task automatic m_pick(input logic [2:0] r);
    if (r[2]) begin
      m_owner = 2;
    end else begin
      m_owner = has_req(r, m_first) ? m_first : 1 - m_first;
      m_first = 1 - m_owner;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then
  // compare all outputs 1 time unit later.
  task automatic tick();
    logic [2:0]  r;
    logic [15:0] w;
    logic [3:0]  m;
    logic [3:0]  d;
    logic [7:0]  e_seg;
    logic [3:0]  e_en;
    logic [2:0]  e_grant;
    int dig;
    @(posedge clk);
    r = bus.req;
    if (!rst_n) begin
      m_mode = M_IDLE; m_first = 0; m_age = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (r != 3'b000) begin m_mode = M_BLANK; m_pick(r); end
        M_BLANK: begin m_mode = M_SHOW; m_age = 0; end
        default: begin
          m_age++;
          if (!has_req(r, m_owner)) begin
            if (r != 3'b000) begin m_mode = M_BLANK; m_pick(r); end
            else m_mode = M_IDLE;
          end else if (m_owner != 2 && r[2]) begin
            m_mode = M_BLANK; m_owner = 2;
          end else if (m_owner != 2 && m_age >= MH && has_req(r, 1 - m_owner)) begin
            m_mode = M_BLANK; m_first = m_owner; m_owner = 1 - m_owner;
          end
        end
      endcase
    end
    e_seg = 8'h00; e_en = 4'h0; e_grant = 3'b000;
    if (m_mode == M_SHOW) begin
      dig = (m_age / ST) % 4;
      case (m_owner)
        0: begin w = bus.bcd0; m = bus.dp0; end
        1: begin w = bus.bcd1; m = bus.dp1; end
        default: begin w = bus.bcd2; m = bus.dp2; end
      endcase
      d = w[dig*4 +: 4];
      e_en    = 4'b0001 << dig;
      e_seg   = ref_glyph(d, m[dig]);
      e_grant = 3'b001 << m_owner;
    end
    #1;
    check("seg_out",   bus.seg_out, e_seg);
    check("seg_en",    {4'h0, bus.seg_en}, {4'h0, e_en});
    check("grant",     {5'h00, bus.grant}, {5'h00, e_grant});
    check("switching", {7'h00, bus.switching}, {7'h00, m_mode == M_BLANK});
  endtask

  initial begin
    bus.req = 3'b000;
    bus.bcd0 = 16'h0000; bus.bcd1 = 16'h0000; bus.bcd2 = 16'h0000;
    bus.dp0 = 4'h0; bus.dp1 = 4'h0; bus.dp2 = 4'h0;

    // reset state
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // single owner scan across all four digits
    bus.bcd0 = 16'h1234; bus.dp0 = 4'b0010; bus.req = 3'b001;
    repeat (20) tick();

    // round-robin rotation between requesters 0 and 1
    bus.bcd1 = 16'h5678; bus.dp1 = 4'b1000; bus.req = 3'b011;
    repeat (70) tick();

    // alert preempts owner 0 after 5 cycles, then returns to requester 0
    for (int i = 0; i < 100; i++) begin
      if (m_mode == M_SHOW && m_owner == 0 && m_age == 5) break;
      tick();
    end
    bus.bcd2 = 16'h9090; bus.dp2 = 4'b0101; bus.req = 3'b111;
    repeat (10) tick();
    bus.req = 3'b001;
    repeat (6) tick();

    // codes 10-15 blank the glyph but keep the decimal point
    bus.bcd0 = 16'hFCBA; bus.dp0 = 4'hF;
    repeat (18) tick();

    // owner drops with nothing else pending
    bus.req = 3'b000;
    repeat (3) tick();

    // randomized traffic
    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 9) == 0) bus.req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) begin
        bus.bcd0 = 16'($urandom); bus.bcd1 = 16'($urandom); bus.bcd2 = 16'($urandom);
        bus.dp0 = 4'($urandom); bus.dp1 = 4'($urandom); bus.dp2 = 4'($urandom);
      end
      tick();
    end

    // asynchronous reset while owning, release with requester 1
    bus.req = 3'b001;
    repeat (8) tick();
    rst_n = 1'b0;
    #1;
    check("rst_async_seg_en",    {4'h0, bus.seg_en}, 8'h00);
    check("rst_async_grant",     {5'h00, bus.grant}, 8'h00);
    check("rst_async_seg_out",   bus.seg_out, 8'h00);
    check("rst_async_switching", {7'h00, bus.switching}, 8'h00);
    bus.req = 3'b010;
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    bus.req = 3'b000;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
